// File: rtl/branch_resolve_queue_pkg.sv
// ============================================================================
// Module   : branch_resolve_queue_pkg
// Brief    : Shared predictor defaults and the saturating-increment helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolve_queue_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 1;

  // Holds at max_value instead of wrapping; callers narrow the result.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_queue_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO storage with occupancy count; no overflow guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int width = 2,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         head_data,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                  c_ptr_w      = $clog2(depth);
  localparam logic [c_ptr_w:0]    c_full_count = (c_ptr_w + 1)'(depth);

  logic [width-1:0]   r_mem [depth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  // Depth is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == c_full_count);
  assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module   : branch_resolve_queue
// Brief    : Tracks in-flight branch predictions and trains on resolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int address_width = DEFAULT_ADDRESS_WIDTH,
  parameter int depth         = 4,
  parameter int count_width   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [address_width-1:0] pred_address,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     update_enable,
  output logic [address_width-1:0] update_address,
  output logic                     update_result,
  output logic                     mispredict,
  output logic [$clog2(depth):0]   occupancy,
  output logic [count_width-1:0]   branch_count,
  output logic [count_width-1:0]   mispredict_count,
  output logic                     underflow_error
);

  localparam logic [count_width-1:0] c_count_max = '1;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_mismatch;
  logic [address_width:0]   w_head;

  logic                     r_update_enable;
  logic [address_width-1:0] r_update_address;
  logic                     r_update_result;
  logic                     r_mispredict;
  logic [count_width-1:0]   r_branch_count;
  logic [count_width-1:0]   r_mispredict_count;
  logic                     r_underflow_error;

  // Both qualifiers use pre-edge state, so a pop never frees room for a push.
  assign pred_ready = ~w_full;
  assign w_push     = pred_valid & ~w_full;
  assign w_pop      = resolve_valid & ~w_empty;
  assign w_mismatch = w_head[0] ^ resolve_taken;

  sync_fifo #(
    .width (address_width + 1),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({pred_address, pred_taken}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (occupancy),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_update_enable    <= 1'b0;
      r_update_address   <= '0;
      r_update_result    <= 1'b0;
      r_mispredict       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
      r_underflow_error  <= 1'b0;
    end else begin
      r_update_enable <= w_pop;
      r_mispredict    <= w_pop & w_mismatch;
      if (w_pop) begin
        r_update_address <= w_head[address_width:1];
        r_update_result  <= resolve_taken;
        r_branch_count   <= count_width'(sat_inc(64'(r_branch_count), 64'(c_count_max)));
        if (w_mismatch)
          r_mispredict_count <= count_width'(sat_inc(64'(r_mispredict_count), 64'(c_count_max)));
      end
      if (resolve_valid && w_empty) r_underflow_error <= 1'b1;
    end
  end

  assign update_enable    = r_update_enable;
  assign update_address   = r_update_address;
  assign update_result    = r_update_result;
  assign mispredict       = r_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
  assign underflow_error  = r_underflow_error;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module   : tb_branch_resolve_queue
// Brief    : Directed-vector bench for branch_resolve_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [3:0] pred_address;
  logic       pred_taken;
  logic       resolve_valid;
  logic       resolve_taken;

  logic       pred_ready;
  logic       update_enable;
  logic [3:0] update_address;
  logic       update_result;
  logic       mispredict;
  logic [2:0] occupancy;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic       underflow_error;

  logic       s_pred_ready;
  logic       s_update_enable;
  logic [0:0] s_update_address;
  logic       s_update_result;
  logic       s_mispredict;
  logic [2:0] s_occupancy;
  logic [1:0] s_branch_count;
  logic [1:0] s_mispredict_count;
  logic       s_underflow_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.address_width(4), .depth(4), .count_width(16)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_address(pred_address),
    .pred_taken(pred_taken), .pred_ready(pred_ready), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .update_enable(update_enable),
    .update_address(update_address), .update_result(update_result),
    .mispredict(mispredict), .occupancy(occupancy), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .underflow_error(underflow_error)
  );

  branch_resolve_queue #(.count_width(2)) dut_sat (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_address(pred_address[0:0]),
    .pred_taken(pred_taken), .pred_ready(s_pred_ready), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .update_enable(s_update_enable),
    .update_address(s_update_address), .update_result(s_update_result),
    .mispredict(s_mispredict), .occupancy(s_occupancy), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count), .underflow_error(s_underflow_error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pred_valid = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic do_reset;
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset;
    pred_address = '0; pred_taken = 1'b0; resolve_taken = 1'b0;
    do_reset();
    vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    vectors++; if (pred_ready !== 1'b1) begin miscompares++; $display("FAIL reset_pred_ready got %b exp 1", pred_ready); end
    vectors++; if ({update_enable, mispredict, update_result} !== 3'b000) begin miscompares++; $display("FAIL reset_update got %b exp 000", {update_enable, mispredict, update_result}); end
    vectors++; if (update_address !== 4'd0) begin miscompares++; $display("FAIL reset_update_address got %0d exp 0", update_address); end
    vectors++; if ({branch_count, mispredict_count} !== 32'd0) begin miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_count, mispredict_count); end
    vectors++; if (underflow_error !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b exp 0", underflow_error); end
  endtask

  task automatic test_mispredict;
    pred_valid = 1'b1; pred_address = 4'd0; pred_taken = 1'b1;
    tick();
    pred_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b0;
    vectors++; if (update_enable !== 1'b0) begin miscompares++; $display("FAIL mp_no_early_update got %b exp 0", update_enable); end
    tick();
    idle();
    vectors++; if ({update_enable, update_result, mispredict} !== 3'b101) begin miscompares++; $display("FAIL mp_update en/res/mp got %b exp 101", {update_enable, update_result, mispredict}); end
    vectors++; if (update_address !== 4'd0) begin miscompares++; $display("FAIL mp_address got %0d exp 0", update_address); end
    vectors++; if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin miscompares++; $display("FAIL mp_counters got %0d/%0d exp 1/1", branch_count, mispredict_count); end
    vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL mp_occupancy got %0d exp 0", occupancy); end
    tick();
    vectors++; if ({update_enable, mispredict} !== 2'b00) begin miscompares++; $display("FAIL mp_pulse_width got %b exp 00", {update_enable, mispredict}); end
    vectors++; if (update_result !== 1'b0) begin miscompares++; $display("FAIL mp_result_hold got %b exp 0", update_result); end
  endtask

  task automatic test_full;
    for (int i = 1; i <= 4; i++) begin
      pred_valid = 1'b1; pred_address = 4'(i); pred_taken = 1'b0;
      tick();
    end
    vectors++; if (pred_ready !== 1'b0) begin miscompares++; $display("FAIL full_pred_ready got %b exp 0", pred_ready); end
    vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL full_occupancy got %0d exp 4", occupancy); end
    pred_address = 4'd5; resolve_valid = 1'b1; resolve_taken = 1'b0;
    tick();
    pred_valid = 1'b0;
    vectors++; if (occupancy !== 3'd3) begin miscompares++; $display("FAIL full_push_refused occupancy got %0d exp 3", occupancy); end
    vectors++; if (update_enable !== 1'b1 || update_address !== 4'd1 || mispredict !== 1'b0) begin miscompares++; $display("FAIL full_pop got en=%b addr=%0d mp=%b exp 1/1/0", update_enable, update_address, mispredict); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      vectors++; if (update_enable !== 1'b1 || update_address !== 4'(i)) begin miscompares++; $display("FAIL full_drain got en=%b addr=%0d exp 1/%0d", update_enable, update_address, i); end
    end
    idle();
    vectors++; if (occupancy !== 3'd0 || branch_count !== 16'd5 || mispredict_count !== 16'd1) begin miscompares++; $display("FAIL full_end got occ=%0d bc=%0d mc=%0d exp 0/5/1", occupancy, branch_count, mispredict_count); end
  endtask

  task automatic test_underflow;
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    pred_valid = 1'b1; pred_address = 4'd6; pred_taken = 1'b1;
    tick();
    idle();
    vectors++; if (underflow_error !== 1'b1) begin miscompares++; $display("FAIL uf_flag got %b exp 1", underflow_error); end
    vectors++; if (occupancy !== 3'd1) begin miscompares++; $display("FAIL uf_push_accepted occupancy got %0d exp 1", occupancy); end
    vectors++; if (branch_count !== 16'd5 || mispredict_count !== 16'd1) begin miscompares++; $display("FAIL uf_counters got %0d/%0d exp 5/1", branch_count, mispredict_count); end
    tick();
    vectors++; if (update_enable !== 1'b0 || underflow_error !== 1'b1) begin miscompares++; $display("FAIL uf_sticky got en=%b uf=%b exp 0/1", update_enable, underflow_error); end
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    idle();
    vectors++; if (update_enable !== 1'b1 || update_address !== 4'd6 || mispredict !== 1'b0 || update_result !== 1'b1) begin miscompares++; $display("FAIL uf_no_bypass got en=%b addr=%0d mp=%b res=%b exp 1/6/0/1", update_enable, update_address, mispredict, update_result); end
    vectors++; if (underflow_error !== 1'b1) begin miscompares++; $display("FAIL uf_still_set got %b exp 1", underflow_error); end
    do_reset();
    vectors++; if (underflow_error !== 1'b0) begin miscompares++; $display("FAIL uf_cleared_by_rst got %b exp 0", underflow_error); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_addr;
    logic       exp_mp;
    pred_valid = 1'b1; pred_address = 4'd1; pred_taken = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      pred_valid = 1'b1; pred_address = 4'(3 * i + 1); pred_taken = i[0];
      resolve_valid = 1'b1; resolve_taken = 1'b1;
      tick();
      exp_addr = 4'(3 * (i - 1) + 1);
      exp_mp   = ((i - 1) % 2) == 0;
      vectors++; if (update_enable !== 1'b1 || update_address !== exp_addr || mispredict !== exp_mp) begin miscompares++; $display("FAIL wrap_%0d got en=%b addr=%0d mp=%b exp 1/%0d/%b", i, update_enable, update_address, mispredict, exp_addr, exp_mp); end
      vectors++; if (occupancy !== 3'd1) begin miscompares++; $display("FAIL wrap_occ_%0d got %0d exp 1", i, occupancy); end
    end
    pred_valid = 1'b0;
    tick();
    idle();
    vectors++; if (update_address !== 4'd9 || mispredict !== 1'b1 || occupancy !== 3'd0) begin miscompares++; $display("FAIL wrap_last got addr=%0d mp=%b occ=%0d exp 9/1/0", update_address, mispredict, occupancy); end
    vectors++; if (branch_count !== 16'd9 || mispredict_count !== 16'd5) begin miscompares++; $display("FAIL wrap_counters got %0d/%0d exp 9/5", branch_count, mispredict_count); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pred_valid = 1'b1; pred_address = 4'd0; pred_taken = 1'b1;
      tick();
      pred_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b0;
      tick();
      resolve_valid = 1'b0;
    end
    vectors++; if (s_branch_count !== 2'd3 || s_mispredict_count !== 2'd3) begin miscompares++; $display("FAIL sat_counters got %0d/%0d exp 3/3", s_branch_count, s_mispredict_count); end
    vectors++; if (branch_count !== 16'd5 || mispredict_count !== 16'd5) begin miscompares++; $display("FAIL wide_counters got %0d/%0d exp 5/5", branch_count, mispredict_count); end
  endtask

  task automatic test_reset_flush;
    for (int i = 0; i < 2; i++) begin
      pred_valid = 1'b1; pred_address = 4'(10 + i); pred_taken = 1'b0;
      tick();
    end
    pred_valid = 1'b0;
    vectors++; if (occupancy !== 3'd2) begin miscompares++; $display("FAIL flush_pre_occ got %0d exp 2", occupancy); end
    rst = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    rst = 1'b0; resolve_valid = 1'b0;
    vectors++; if (occupancy !== 3'd0 || update_enable !== 1'b0) begin miscompares++; $display("FAIL flush_post got occ=%0d en=%b exp 0/0", occupancy, update_enable); end
    tick();
    vectors++; if (update_enable !== 1'b0 || branch_count !== 16'd0 || pred_ready !== 1'b1) begin miscompares++; $display("FAIL flush_no_pulse got en=%b bc=%0d rdy=%b exp 0/0/1", update_enable, branch_count, pred_ready); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_mispredict();
    test_full();
    test_underflow();
    test_back_to_back();
    test_saturate();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The block SHALL take parameter address_width, default 1: width of the branch address field.
REQ-002 The block SHALL take parameter depth, default 4: number of in-flight predictions; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL take parameter count_width, default 16: width of each statistics counter.
REQ-004 The block SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have pred_valid  input  1  a prediction is being issued this cycle.
REQ-007 The block SHALL have pred_address  input  address_width  address of the predicted branch.
REQ-008 The block SHALL have pred_taken  input  1  predicted direction (1 = taken).
REQ-009 The block SHALL have pred_ready  output  1  the queue can accept a prediction; equals not full.
REQ-010 The block SHALL have resolve_valid  input  1  the oldest outstanding branch resolves this cycle.
REQ-011 The block SHALL have resolve_taken  input  1  actual branch direction.
REQ-012 The block SHALL have update_enable  output  1  one-cycle pulse that trains the predictor.
REQ-013 The block SHALL have update_address  output  address_width  address to train.
REQ-014 The block SHALL have update_result  output  1  actual outcome to train with.
REQ-015 The block SHALL have mispredict  output  1  one-cycle pulse, coincident with update_enable, when predicted differs from actual.
REQ-016 The block SHALL have occupancy  output  log2(depth)+1  number of queued entries.
REQ-017 The block SHALL have branch_count and mispredict_count  output  count_width each  statistics.
REQ-018 The block SHALL have underflow_error  output  1  sticky flag.

Function
REQ-019 A push SHALL occur when pred_valid and pred_ready are both 1; it stores {pred_address, pred_taken} at the tail.
REQ-020 A pop SHALL occur when resolve_valid is 1 and occupancy is non-zero; it removes the head entry in FIFO order.
REQ-021 On a pop, on the next rising edge the block SHALL drive: update_enable=1, update_address=head address, update_result=resolve_taken, and mispredict=(head pred_taken XOR resolve_taken). Latency is 1 cycle.
REQ-022 update_enable and mispredict SHALL be 0 in every cycle that does not follow a pop; update_address and update_result SHALL hold their last values.
REQ-023 A simultaneous push and pop SHALL both take effect, leaving occupancy unchanged; pred_ready SHALL be computed from the pre-edge occupancy, so a push while full is refused even if a pop occurs in the same cycle.
REQ-024 A resolve_valid while empty SHALL set underflow_error, produce no update pulse, and not change counters; a same-cycle push SHALL still be accepted, with no bypass.
REQ-025 Head and tail pointers SHALL wrap modulo depth; full is occupancy==depth, empty is occupancy==0.
REQ-026 branch_count SHALL increment on each pop; mispredict_count SHALL increment on each pop with a mismatch; both SHALL saturate at all-ones and never wrap.
REQ-027 Counters, occupancy and outputs SHALL update in the same edge as the event causing them, except the update/mispredict outputs (REQ-021).

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set occupancy=0, pointers=0, update_enable=0, update_address=0, update_result=0, mispredict=0, both counters=0 and underflow_error=0.
REQ-029 Reset SHALL take priority over push and pop in the same cycle; in-flight entries SHALL be discarded with no update pulse.
REQ-030 pred_ready SHALL be 1 in the cycle after reset.

Structure
REQ-031 The team's shared predictor package SHALL hold the default address_width and the saturating-increment helper; the block SHALL need no new typedefs.
REQ-032 Storage SHALL be one sub-module, sync_fifo, parameterised by width (address_width+1) and depth; control, compare and counters SHALL stay in branch_resolve_queue.
REQ-033 The block SHALL map to 120-400 lines of RTL; it SHALL contain no combinational path from resolve_valid to update_enable.

Verification
REQ-034 Bench SHALL push (A=0,taken=1), then resolve taken=0 -> the next cycle shows update_enable=1, update_address=0, update_result=0, mispredict=1, branch_count=1, mispredict_count=1.
REQ-035 Bench SHALL push 4 entries with depth=4 -> pred_ready=0 and occupancy=4; a 5th push plus a pop in the same cycle -> the push is refused and occupancy=3.
REQ-036 Bench SHALL do a resolve while empty -> underflow_error=1 and stays 1, no update pulse, counters unchanged; after rst, underflow_error=0.
REQ-037 Bench SHALL run 8 push/pop pairs with wrap-around -> updates appear in push order with the correct addresses.
REQ-038 Bench SHALL run with count_width=2 and 5 mispredicted pops -> mispredict_count=3 and branch_count=3 (saturated).
REQ-039 Bench SHALL assert rst with 2 entries queued -> occupancy=0 and no update pulse follows.
